// File: rtl/not_arb_pkg.sv
// Shared definitions for the NOT-unit arbiter slice.
//   N_REQ_DEF   : default number of requesters sharing the inverter
//   DATA_W_DEF  : default operand/result width
//   arb_state_e : result-holding state (IDLE = nothing held, HOLD = dout valid)
package not_arb_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/not_rr_arbiter_rr_pick.sv
// Rotating-priority picker: finds the first asserted request searching upward
// from ptr, wrapping from N-1 back to 0. Purely combinational.
//   req    : request vector
//   ptr    : index with highest priority this cycle
//   onehot : one-hot winner (all-zero when req is all-zero)
//   idx    : binary index of the winner (0 when req is all-zero)
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;
    logic           found;

    always_comb begin
        // Rotate so that bit 0 of rot corresponds to requester ptr; the
        // offset of the first set bit is then added back modulo N.
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        off   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx    = sum[IW-1:0];
        onehot = '0;
        if (found) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/not_rr_arbiter.sv
// Round-robin arbiter in front of a shared bitwise-NOT unit with a one-entry
// registered result stage.
//   clk, rst    : clock, asynchronous active-high reset
//   req         : per-requester level request, held until granted
//   din         : operands, requester i at [i*DATA_W +: DATA_W]
//   gnt         : one-hot combinational accept strobe
//   dout        : ~operand of the last granted requester
//   dout_valid  : dout holds a result
//   dout_id     : requester that owns dout
//   dout_ready  : consumer takes dout this cycle
//   dbg_state   : current FSM state, for observation only
//
// Handshake: a requester's operand is taken in the cycle gnt[i]=1 (req is the
// valid, gnt the ready). The result is transferred in any cycle where
// dout_valid=1 and dout_ready=1; while dout_valid=1 and dout_ready=0, dout and
// dout_id stay stable and no new request is granted.
module not_rr_arbiter
    import not_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    din,
    output logic [N_REQ-1:0]           gnt,
    output logic [DATA_W-1:0]          dout,
    output logic                       dout_valid,
    output logic [$clog2(N_REQ)-1:0]   dout_id,
    input  logic                       dout_ready,
    output arb_state_e                 dbg_state
);

    localparam int IDW = $clog2(N_REQ);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic             accept;

    rr_pick #(.N(N_REQ)) u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // The result slot is free when empty or being drained this cycle. rst is
    // included so gnt reads zero for the whole reset pulse.
    assign accept = !rst && (|req) && ((state == IDLE) || dout_ready);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = HOLD;
            HOLD: begin
                if (accept) begin
                    state_nxt = HOLD;
                end else if (dout_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        gnt        = accept ? pick_oh : '0;
        dout_valid = (state == HOLD);
        dbg_state  = state;
    end

    // Result and pointer registers; only an accept moves them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout    <= '0;
            dout_id <= '0;
            rr_ptr  <= '0;
        end else if (accept) begin
            dout    <= ~din[pick_idx*DATA_W +: DATA_W];
            dout_id <= pick_idx;
            rr_ptr  <= (pick_idx == IDW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_not_rr_arbiter.sv
module tb_not_rr_arbiter;
    import not_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*W-1:0]    din;
    logic [N-1:0]      gnt;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic [IW-1:0]     dout_id;
    logic              dout_ready;
    arb_state_e        dbg_state;

    int checks = 0;
    int errors = 0;

    // expected {dout_id, dout} for each accept, in order
    logic [IW+W-1:0] exp_q[$];

    not_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .din        (din),
        .gnt        (gnt),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_id    (dout_id),
        .dout_ready (dout_ready),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs at the falling edge, checks the combinational
    // gnt, and queues the hand-computed result when a grant is expected.
    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy,
                        input logic [N-1:0] exp_gnt, input int exp_id, input logic [W-1:0] exp_dout);
        @(negedge clk);
        req        = r;
        din        = d;
        dout_ready = rdy;
        #1;
        check_eq("gnt", 32'(gnt), 32'(exp_gnt));
        if (exp_gnt != '0) exp_q.push_back({exp_id[IW-1:0], exp_dout});
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic          took;
        logic          held;
        logic [W-1:0]  hold_dout;
        logic [IW-1:0] hold_id;
        logic [IW+W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            checks++;
            if (!((gnt & (gnt - 1'b1)) == '0)) begin
                errors++;
                $display("FAIL gnt_onehot: got %b expected one-hot or zero at %0t", gnt, $time);
            end
            took      = |gnt;
            held      = dout_valid && !dout_ready;
            hold_dout = dout;
            hold_id   = dout_id;
            @(posedge clk);
            #1;
            if (took) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got result id %0d dout %0h expected none", dout_id, dout);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_valid", 32'(dout_valid), 32'd1);
                    check_eq("sb_dout", 32'(dout), 32'(e[W-1:0]));
                    check_eq("sb_id", 32'(dout_id), 32'(e[IW+W-1:W]));
                end
            end else if (held && !rst) begin
                check_eq("hold_valid", 32'(dout_valid), 32'd1);
                check_eq("hold_dout", 32'(dout), 32'(hold_dout));
                check_eq("hold_id", 32'(dout_id), 32'(hold_id));
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [N*W-1:0] D4 = {8'h88, 8'h44, 8'h22, 8'h11};

    initial begin
        rst        = 1'b1;
        req        = 4'b1111;
        din        = D4;
        dout_ready = 1'b0;
        #12;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_valid", 32'(dout_valid), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_id", 32'(dout_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = '0;

        // single request
        step(4'b0001, 32'h0000_00A5, 1'b0, 4'b0001, 0, 8'h5A);
        step(4'b0000, D4, 1'b1, 4'b0000, 0, 8'h00);
        step(4'b0000, D4, 1'b1, 4'b0000, 0, 8'h00);
        check_eq("idle_valid", 32'(dout_valid), 32'd0);

        // bring pointer to 0, then fairness with all requesting
        step(4'b1000, D4, 1'b0, 4'b1000, 3, 8'h77);
        step(4'b1111, D4, 1'b1, 4'b0001, 0, 8'hEE);
        step(4'b1111, D4, 1'b1, 4'b0010, 1, 8'hDD);
        step(4'b1111, D4, 1'b1, 4'b0100, 2, 8'hBB);
        step(4'b1111, D4, 1'b1, 4'b1000, 3, 8'h77);
        step(4'b1111, D4, 1'b1, 4'b0001, 0, 8'hEE);
        step(4'b0000, D4, 1'b1, 4'b0000, 0, 8'h00);

        // backpressure: pointer is 1, IDLE ignores dout_ready
        step(4'b0001, D4, 1'b1, 4'b0001, 0, 8'hEE);
        for (int i = 0; i < 3; i++) step(4'b0110, D4, 1'b0, 4'b0000, 0, 8'h00);
        step(4'b0110, D4, 1'b1, 4'b0010, 1, 8'hDD);

        // wrap-around: pointer 2 -> 3, then 3 -> 0 -> 1
        step(4'b0100, D4, 1'b1, 4'b0100, 2, 8'hBB);
        step(4'b1001, D4, 1'b1, 4'b1000, 3, 8'h77);
        step(4'b1001, D4, 1'b1, 4'b0001, 0, 8'hEE);
        step(4'b0000, D4, 1'b0, 4'b0000, 0, 8'h00);
        check_eq("hold_before_rst", 32'(dout_valid), 32'd1);

        // asynchronous reset between edges while holding a result
        @(posedge clk);
        #3;
        req = 4'b1111;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(dout_valid), 32'd0);
        check_eq("mid_rst_dout", 32'(dout), 32'd0);
        check_eq("mid_rst_id", 32'(dout_id), 32'd0);
        check_eq("mid_rst_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        req        = 4'b0100;
        din        = 32'h00FF_0000;
        dout_ready = 1'b0;
        #1;
        check_eq("post_rst_gnt", 32'(gnt), 32'b0100);
        exp_q.push_back({2'd2, 8'h00});
        step(4'b0000, D4, 1'b1, 4'b0000, 0, 8'h00);
        step(4'b0000, D4, 1'b0, 4'b0000, 0, 8'h00);
        check_eq("end_valid", 32'(dout_valid), 32'd0);

        repeat (2) @(posedge clk);
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
